// File: rtl/packet_sync_detector.sv
// packet_sync_detector
//   Stream framer. It scans a W-bit word stream for an N-word sync header
//   (PATTERN, sent MSB word first). It then forwards PAYLOAD_LEN payload
//   words with valid/last marking, and counts completed frames.
//   All outputs are registered, so every response appears one cycle after
//   the input word that caused it.
//
//   Optional feature macro: PKT_TIMEOUT_EN
//     When defined, a frame that is part-way through the header or payload
//     is abandoned after TIMEOUT consecutive cycles with in_valid low.
//     The abandon is signalled by a one-cycle pulse on timeout.
//     When undefined, the gap counter is not built, timeout is tied low,
//     and frames wait across gaps of any length.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    in_data is valid this cycle (no backpressure)
//   in_data     stream word
//   hdr_match   pulse: complete header accepted
//   pay_valid   pulse: pay_data carries a payload word
//   pay_data    payload word (holds its last value between words)
//   pay_last    pulse with pay_valid on the final payload word
//   frame_done  pulse coincident with pay_last
//   timeout     pulse: frame abandoned on an input gap
//   state       FSM state: 00 IDLE, 01 HDR, 10 PAY
//   frame_cnt   completed frames, saturating at 16'hFFFF
module packet_sync_detector #(
  parameter int W           = 8,
  parameter int N           = 3,
  parameter logic [N*W-1:0] PATTERN = 24'hAA55F0,
  parameter int PAYLOAD_LEN = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         hdr_match,
  output logic         pay_valid,
  output logic [W-1:0] pay_data,
  output logic         pay_last,
  output logic         frame_done,
  output logic         timeout,
  output logic [1:0]   state,
  output logic [15:0]  frame_cnt
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HDR  = 2'b01,
    S_PAY  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   hdr_idx;
  logic [7:0]      pay_cnt;
  logic [W-1:0]    hdr_words [N];

  // Split the packed header pattern into words, with word 0 taken from the MSBs.
  for (genvar i = 0; i < N; i++) begin : g_hdr
    assign hdr_words[i] = PATTERN[(N-1-i)*W +: W];
  end

  assign state = state_q;

`ifdef PKT_TIMEOUT_EN
  logic [15:0] gap_cnt;
  logic        timeout_q;
  assign timeout = timeout_q;
`else
  // Constant 0. The comparison only references TIMEOUT so the parameter is consumed.
  assign timeout = (TIMEOUT < 0);
`endif

  // Framer FSM with registered outputs. Pulse outputs default low each cycle.
  // In the timeout build, the gap check comes after the case statement so that
  // an expired gap overrides the state chosen by the case.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hdr_idx    <= '0;
      pay_cnt    <= '0;
      hdr_match  <= 1'b0;
      pay_valid  <= 1'b0;
      pay_data   <= '0;
      pay_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef PKT_TIMEOUT_EN
      gap_cnt    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      hdr_match  <= 1'b0;
      pay_valid  <= 1'b0;
      pay_last   <= 1'b0;
      frame_done <= 1'b0;
`ifdef PKT_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_data == hdr_words[0]) begin
            state_q <= S_HDR;
            hdr_idx <= IW'(1);
          end
        end
        S_HDR: begin
          if (in_valid) begin
            if (in_data == hdr_words[hdr_idx]) begin
              if (hdr_idx == IW'(N-1)) begin
                state_q   <= S_PAY;
                hdr_idx   <= '0;
                pay_cnt   <= '0;
                hdr_match <= 1'b1;
              end else begin
                hdr_idx <= hdr_idx + 1'b1;
              end
            end else if (in_data == hdr_words[0]) begin
              // A failed header word that equals word 0 restarts the header at index 1.
              // No longer partial-match overlap is searched for.
              hdr_idx <= IW'(1);
            end else begin
              state_q <= S_IDLE;
              hdr_idx <= '0;
            end
          end
        end
        S_PAY: begin
          // Payload words are forwarded unconditionally, even if they look like header words.
          if (in_valid) begin
            pay_valid <= 1'b1;
            pay_data  <= in_data;
            if (pay_cnt == 8'(PAYLOAD_LEN-1)) begin
              pay_last   <= 1'b1;
              frame_done <= 1'b1;
              state_q    <= S_IDLE;
              pay_cnt    <= '0;
              if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            end else begin
              pay_cnt <= pay_cnt + 8'd1;
            end
          end
        end
        default: begin
          // Unreachable encoding: return to IDLE with all pulses left low.
          state_q <= S_IDLE;
          hdr_idx <= '0;
          pay_cnt <= '0;
        end
      endcase
`ifdef PKT_TIMEOUT_EN
      // The gap counter runs only while a frame is open. A valid word clears it,
      // and a valid word on the limit cycle therefore prevents the timeout.
      if (state_q == S_HDR || state_q == S_PAY) begin
        if (in_valid) begin
          gap_cnt <= '0;
        end else if (gap_cnt == 16'(TIMEOUT-1)) begin
          gap_cnt   <= '0;
          state_q   <= S_IDLE;
          hdr_idx   <= '0;
          pay_cnt   <= '0;
          timeout_q <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end else begin
        gap_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_packet_sync_detector.sv
// tb_packet_sync_detector
//   Bench for packet_sync_detector with W=8, N=3, PATTERN=AA55F0,
//   PAYLOAD_LEN=4 and TIMEOUT=8.
//   On every clock cycle the bench predicts the registered outputs from a
//   reference model and queues that prediction. One cycle later the
//   prediction is popped and compared against the DUT outputs.
module tb_packet_sync_detector;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        hdr_match, pay_valid, pay_last, frame_done, timeout;
  logic [7:0]  pay_data;
  logic [1:0]  state;
  logic [15:0] frame_cnt;

  packet_sync_detector #(
    .W(8), .N(3), .PATTERN(24'hAA55F0), .PAYLOAD_LEN(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .hdr_match(hdr_match), .pay_valid(pay_valid), .pay_data(pay_data),
    .pay_last(pay_last), .frame_done(frame_done), .timeout(timeout),
    .state(state), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hm, pv, pl, fd, to;
    logic [7:0]  pd;
    logic [1:0]  st;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state, updated one word at a time.
  logic [7:0]  hdr [3] = '{8'hAA, 8'h55, 8'hF0};
  logic [1:0]  m_state = 2'b00;
  int          m_idx = 0, m_cnt = 0, m_gap = 0;
  logic [15:0] m_frames = 16'd0;
  logic [7:0]  m_pd = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs === expv) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
  endtask

  // Advance the reference model by one cycle and return the outputs it predicts.
  function automatic exp_t modelStep(input logic v, input logic [7:0] d, input logic rst);
    exp_t e;
    logic [1:0] prev;
    e = '0;
    if (rst) begin
      m_state = 2'b00; m_idx = 0; m_cnt = 0; m_gap = 0; m_frames = 0; m_pd = 0;
    end else begin
      prev = m_state;
      if (v) begin
        if (m_state == 2'b00) begin
          if (d == hdr[0]) begin m_state = 2'b01; m_idx = 1; end
        end else if (m_state == 2'b01) begin
          if (d == hdr[m_idx]) begin
            if (m_idx == 2) begin m_state = 2'b10; m_cnt = 0; m_idx = 0; e.hm = 1; end
            else m_idx++;
          end else if (d == hdr[0]) m_idx = 1;
          else begin m_state = 2'b00; m_idx = 0; end
        end else begin
          e.pv = 1; m_pd = d;
          if (m_cnt == 3) begin
            e.pl = 1; e.fd = 1; m_state = 2'b00; m_cnt = 0;
            if (m_frames != 16'hFFFF) m_frames++;
          end else m_cnt++;
        end
      end
`ifdef PKT_TIMEOUT_EN
      if (prev != 2'b00) begin
        if (v) m_gap = 0;
        else if (m_gap == TO - 1) begin
          m_gap = 0; m_state = 2'b00; m_idx = 0; m_cnt = 0; e.to = 1;
        end else m_gap++;
      end else m_gap = 0;
`endif
    end
    e.pd = m_pd; e.st = m_state; e.fc = m_frames;
    return e;
  endfunction

  // Pop one prediction and compare it with every DUT output.
  task automatic compareCycle();
    exp_t e;
    checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("hdr_match", 32'(hdr_match), 32'(e.hm));
      checkOutput("pay_valid", 32'(pay_valid), 32'(e.pv));
      checkOutput("pay_data", 32'(pay_data), 32'(e.pd));
      checkOutput("pay_last", 32'(pay_last), 32'(e.pl));
      checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
      checkOutput("timeout", 32'(timeout), 32'(e.to));
      checkOutput("state", 32'(state), 32'(e.st));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(e.fc));
    end
  endtask

  // Drive one cycle of inputs, queue the prediction, clock, then compare.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rst = 1'b0);
    reset = rst; in_valid = v; in_data = d;
    exp_q.push_back(modelStep(v, d, rst));
    @(posedge clk); #1;
    compareCycle();
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic sendWords(input logic [7:0] w [], input int gap);
    foreach (w[i]) begin
      applyStimulus(1'b1, w[i]);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00);
    end
  endtask

  initial begin
    logic [7:0] f1 [] = '{8'hAA, 8'h55, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] f2 [] = '{8'hAA, 8'hAA, 8'h55, 8'hF0, 8'h11, 8'h12, 8'h13, 8'h14,
                          8'hAA, 8'h55, 8'h00};
    logic [7:0] f4 [] = '{8'hAA, 8'h55, 8'hF0, 8'hAA, 8'h55, 8'hF0, 8'hAA,
                          8'hAA, 8'h55, 8'hF0, 8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] f5 [] = '{8'hAA, 8'h55, 8'hF0, 8'h21, 8'h22};
    logic [7:0] cand [4] = '{8'hAA, 8'h55, 8'hF0, 8'h3C};

    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Contiguous frame.
    sendWords(f1, 0);
    checkOutput("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Header restart on a repeated AA, then an aborted header.
    sendWords(f2, 0);
    checkOutput("t2_state_idle", 32'(state), 32'd0);

    // Same frame as the first, with 3-cycle gaps between words.
    sendWords(f1, 3);
    checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // Header-like payload, then a back-to-back frame.
    sendWords(f4, 0);
    checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd5);

    // Reset mid-payload, then a fresh frame.
    sendWords(f5, 0);
    applyStimulus(1'b1, 8'h23, 1'b1);
    checkOutput("t5_reset_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("t5_reset_state", 32'(state), 32'd0);
    sendWords(f1, 0);
    checkOutput("t5_fresh_cnt", 32'(frame_cnt), 32'd1);

`ifdef PKT_TIMEOUT_EN
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    for (int i = 0; i < TO; i++) applyStimulus(1'b0, 8'h00);
    checkOutput("t6_state_idle", 32'(state), 32'd0);
    applyStimulus(1'b1, 8'hF0);
    checkOutput("t6_no_match", 32'(hdr_match), 32'd0);
`else
    // Long gap inside a header: without the timeout feature the frame survives it.
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'hF0);
    checkOutput("t6_match_after_gap", 32'(hdr_match), 32'd1);
    sendWords('{8'h31, 8'h32, 8'h33, 8'h34}, 0);
`endif

    // Randomised stream biased toward header words.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), cand[$urandom_range(0, 3)]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
